// File: rtl/commit_tracer_pkg.sv
// commit_tracer_pkg
// Shared types and field widths for the commit tracer.
// Build option: define TRACE_RF_EN to carry the register-write fields in
// every trace entry (ENTRY_W = 102); otherwise entries are {pc, instr}
// only (ENTRY_W = 64).
package commit_tracer_pkg;

    localparam int PC_W      = 32;
    localparam int INSTR_W   = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

`ifdef TRACE_RF_EN
    // {pc[101:70], instr[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
    localparam int ENTRY_W = PC_W + INSTR_W + 1 + RF_ADDR_W + RF_DATA_W;
`else
    // {pc[63:32], instr[31:0]}
    localparam int ENTRY_W = PC_W + INSTR_W;
`endif

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

endpackage

// File: rtl/commit_tracer_trace_fifo.sv
// trace_fifo
// Synchronous FIFO holding captured trace entries.
// Ports:
//   clk, rstn        - clock, asynchronous active-low reset (clears contents)
//   push, wdata      - write request and entry; accepted when not full, or
//                      when full and a pop happens on the same edge
//   pop              - read request; ignored when empty
//   rdata            - oldest entry (zero while empty)
//   full, empty      - occupancy flags
//   count            - current occupancy, 0..DEPTH
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    assign do_push = push && (!full || do_pop);

    // Pointers are AW bits wide, so DEPTH being a power of two makes them
    // wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = empty ? '0 : mem[rptr];
    assign count = cnt;

endmodule

// File: rtl/commit_tracer.sv
// commit_tracer
// Captures retiring CPU instructions into a trace FIFO and drains them over
// a valid/ready stream. Capture stops when the instruction at HALT_PC
// commits (HALTED) or when the RUN cycle budget MAX_CYCLES runs out
// (TIMEOUT); draining continues in both end states.
// Build option: TRACE_RF_EN adds rf_we/rf_waddr/rf_wdata to each entry.
// Ports:
//   clk, rstn                - clock, asynchronous active-low reset
//   commit, pc, instr        - one retiring instruction per cycle
//   rf_we, rf_waddr, rf_wdata - its register write (used with TRACE_RF_EN)
//   cpu_hold                 - stall request while the FIFO is full in RUN
//   tr_valid, tr_ready, tr_data - trace drain stream
//   halted, timeout, ovf, done - status flags (ovf sticky until reset)
//   count                    - FIFO occupancy
module commit_tracer
    import commit_tracer_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter logic [31:0] HALT_PC    = 32'h0000_0048,
    parameter int          MAX_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   commit,
    input  logic [PC_W-1:0]        pc,
    input  logic [INSTR_W-1:0]     instr,
    input  logic                   rf_we,
    input  logic [RF_ADDR_W-1:0]   rf_waddr,
    input  logic [RF_DATA_W-1:0]   rf_wdata,
    output logic                   cpu_hold,
    output logic                   tr_valid,
    input  logic                   tr_ready,
    output logic [ENTRY_W-1:0]     tr_data,
    output logic                   halted,
    output logic                   timeout,
    output logic                   ovf,
    output logic                   done,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CYC_W = $clog2(MAX_CYCLES) + 1;

    state_t             state;
    state_t             state_nxt;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [ENTRY_W-1:0] entry;
    logic               run;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               halt_hit;
    logic               cyc_end;

`ifdef TRACE_RF_EN
    assign entry = {pc, instr, rf_we, rf_waddr, rf_wdata};
`else
    assign entry = {pc, instr};
    // Register-write inputs stay on the port list but are not traced.
    logic unused_rf;
    assign unused_rf = ^{rf_we, rf_waddr, rf_wdata};
`endif

    assign run      = (state == ST_RUN);
    assign push     = run && commit;
    assign pop      = tr_valid && tr_ready;
    assign halt_hit = push && (pc == HALT_PC);
    assign cyc_end  = (cyc_cnt == CYC_W'(MAX_CYCLES - 1));

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .wdata (entry),
        .rdata (tr_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // The halt commit itself is still captured (or dropped as an overflow)
    // on the edge that leaves RUN; halt takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (halt_hit) begin
                    state_nxt = ST_HALTED;
                end else if (cyc_end) begin
                    state_nxt = ST_TIMEOUT;
                end
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_RUN;
            cyc_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (run) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
            // Commit against a full FIFO with no freeing pop is lost.
            if (push && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    assign tr_valid = !empty;
    assign cpu_hold = run && full;
    assign halted   = (state == ST_HALTED);
    assign timeout  = (state == ST_TIMEOUT);
    assign done     = !run && empty;

endmodule

// File: tb/tb_commit_tracer.sv
module tb_commit_tracer;
    import commit_tracer_pkg::*;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] INSTR_K = 32'hA5C3_0000;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               commit = 1'b0;
    logic [31:0]        pc = '0;
    logic [31:0]        instr = '0;
    logic               rf_we = 1'b1;
    logic [4:0]         rf_waddr = 5'd7;
    logic [31:0]        rf_wdata = 32'd5;
    logic               tr_ready = 1'b0;

    logic               cpu_hold, tr_valid, halted, timeout, ovf, done;
    logic [ENTRY_W-1:0] tr_data;
    logic [2:0]         count;

    logic               cpu_hold_t, tr_valid_t, halted_t, timeout_t, ovf_t, done_t;
    logic [ENTRY_W-1:0] tr_data_t;
    logic [2:0]         count_t;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    commit_tracer #(.DEPTH(DEPTH), .HALT_PC(32'h48), .MAX_CYCLES(1000)) dut (
        .clk(clk), .rstn(rstn), .commit(commit), .pc(pc), .instr(instr),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .cpu_hold(cpu_hold), .tr_valid(tr_valid), .tr_ready(tr_ready),
        .tr_data(tr_data), .halted(halted), .timeout(timeout), .ovf(ovf),
        .done(done), .count(count)
    );

    commit_tracer #(.DEPTH(DEPTH), .HALT_PC(32'h48), .MAX_CYCLES(10)) dut_to (
        .clk(clk), .rstn(rstn), .commit(commit), .pc(pc), .instr(instr),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .cpu_hold(cpu_hold_t), .tr_valid(tr_valid_t), .tr_ready(tr_ready),
        .tr_data(tr_data_t), .halted(halted_t), .timeout(timeout_t), .ovf(ovf_t),
        .done(done_t), .count(count_t)
    );

    typedef struct {
        bit          rst;
        bit          commit;
        logic [31:0] pc;
        bit          ready;
        int          exp_count;
        bit          exp_hold;
        bit          exp_ovf;
        logic [31:0] exp_head;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(bit rs, bit c, logic [31:0] p, bit r,
                                int n, bit h, bit o, logic [31:0] hd);
        vec_t v;
        v.rst = rs; v.commit = c; v.pc = p; v.ready = r;
        v.exp_count = n; v.exp_hold = h; v.exp_ovf = o; v.exp_head = hd;
        return v;
    endfunction

    function automatic logic [ENTRY_W-1:0] exp_entry(logic [31:0] p);
        logic [31:0] ins;
        ins = p ^ INSTR_K;
`ifdef TRACE_RF_EN
        return {p, ins, 1'b1, 5'd7, 32'd5};
`else
        return {p, ins};
`endif
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        commit = 1'b0;
        tr_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Drive one cycle of stimulus, let one rising edge pass, return at the falling edge.
    task automatic apply(input bit c, input logic [31:0] p, input bit r);
        commit = c;
        pc = p;
        instr = p ^ INSTR_K;
        tr_ready = r;
        @(posedge clk);
        @(negedge clk);
        commit = 1'b0;
        tr_ready = 1'b0;
    endtask

    initial begin
        // Three in-order beats with the consumer always ready.
        vecs[0]  = mk(1, 1, 32'h00, 1, 1, 0, 0, 32'h00);
        vecs[1]  = mk(0, 1, 32'h04, 1, 1, 0, 0, 32'h04);
        vecs[2]  = mk(0, 1, 32'h08, 1, 1, 0, 0, 32'h08);
        vecs[3]  = mk(0, 0, 32'h00, 1, 0, 0, 0, 32'h00);
        // Fill to DEPTH, overflow the fifth, then drain.
        vecs[4]  = mk(1, 1, 32'h00, 0, 1, 0, 0, 32'h00);
        vecs[5]  = mk(0, 1, 32'h04, 0, 2, 0, 0, 32'h00);
        vecs[6]  = mk(0, 1, 32'h08, 0, 3, 0, 0, 32'h00);
        vecs[7]  = mk(0, 1, 32'h0C, 0, 4, 1, 0, 32'h00);
        vecs[8]  = mk(0, 1, 32'h10, 0, 4, 1, 1, 32'h00);
        vecs[9]  = mk(0, 0, 32'h00, 1, 3, 0, 1, 32'h04);
        vecs[10] = mk(0, 0, 32'h00, 1, 2, 0, 1, 32'h08);
        vecs[11] = mk(0, 0, 32'h00, 1, 1, 0, 1, 32'h0C);
        vecs[12] = mk(0, 0, 32'h00, 1, 0, 0, 1, 32'h00);
        // Full FIFO: commit with a simultaneous pop is accepted without overflow.
        vecs[13] = mk(1, 1, 32'h20, 0, 1, 0, 0, 32'h20);
        vecs[14] = mk(0, 1, 32'h24, 0, 2, 0, 0, 32'h20);
        vecs[15] = mk(0, 1, 32'h28, 0, 3, 0, 0, 32'h20);
        vecs[16] = mk(0, 1, 32'h2C, 0, 4, 1, 0, 32'h20);
        vecs[17] = mk(0, 1, 32'h30, 1, 4, 1, 0, 32'h24);
        vecs[18] = mk(0, 0, 32'h00, 1, 3, 0, 0, 32'h28);
        vecs[19] = mk(0, 0, 32'h00, 1, 2, 0, 0, 32'h2C);
        vecs[20] = mk(0, 0, 32'h00, 1, 1, 0, 0, 32'h30);
        vecs[21] = mk(0, 0, 32'h00, 1, 0, 0, 0, 32'h00);

        // Reset state, observed while rstn is held low.
        #1;
        chk("rst_count",    128'(count),    128'(0));
        chk("rst_valid",    128'(tr_valid), 128'(0));
        chk("rst_data",     128'(tr_data),  128'(0));
        chk("rst_hold",     128'(cpu_hold), 128'(0));
        chk("rst_halted",   128'(halted),   128'(0));
        chk("rst_timeout",  128'(timeout),  128'(0));
        chk("rst_ovf",      128'(ovf),      128'(0));
        chk("rst_done",     128'(done),     128'(0));

        for (int i = 0; i < 22; i++) begin
            if (vecs[i].rst) do_reset();
            apply(vecs[i].commit, vecs[i].pc, vecs[i].ready);
            chk($sformatf("v%0d_count", i), 128'(count), 128'(vecs[i].exp_count));
            chk($sformatf("v%0d_valid", i), 128'(tr_valid), 128'(vecs[i].exp_count != 0));
            chk($sformatf("v%0d_hold", i),  128'(cpu_hold), 128'(vecs[i].exp_hold));
            chk($sformatf("v%0d_ovf", i),   128'(ovf),      128'(vecs[i].exp_ovf));
            if (vecs[i].exp_count != 0)
                chk($sformatf("v%0d_data", i), 128'(tr_data), 128'(exp_entry(vecs[i].exp_head)));
        end

        // Halt commit, ignored later commit, drain to done.
        do_reset();
        apply(1, 32'h44, 0);
        apply(1, 32'h48, 0);
        chk("halt_halted",  128'(halted),  128'(1));
        chk("halt_count",   128'(count),   128'(2));
        chk("halt_timeout", 128'(timeout), 128'(0));
        chk("halt_done0",   128'(done),    128'(0));
        apply(1, 32'h4C, 0);
        chk("halt_ignored", 128'(count),   128'(2));
        chk("halt_head",    128'(tr_data), 128'(exp_entry(32'h44)));
        apply(0, 32'h0, 1);
        chk("halt_head2",   128'(tr_data), 128'(exp_entry(32'h48)));
        chk("halt_done1",   128'(done),    128'(0));
        apply(0, 32'h0, 1);
        chk("halt_empty",   128'(count),   128'(0));
        chk("halt_done",    128'(done),    128'(1));

        // Timeout after ten RUN cycles; later commits ignored.
        do_reset();
        repeat (9) apply(0, 32'h0, 0);
        chk("to_before",    128'(timeout_t), 128'(0));
        apply(0, 32'h0, 0);
        chk("to_flag",      128'(timeout_t), 128'(1));
        chk("to_halted",    128'(halted_t),  128'(0));
        chk("to_done",      128'(done_t),    128'(1));
        apply(1, 32'h4, 0);
        chk("to_ignored",   128'(count_t),   128'(0));
        chk("to_stays",     128'(timeout_t), 128'(1));

        // Halt commit on the final budget cycle: halt wins.
        do_reset();
        repeat (9) apply(0, 32'h0, 0);
        apply(1, 32'h48, 0);
        chk("tie_halted",   128'(halted_t),  128'(1));
        chk("tie_timeout",  128'(timeout_t), 128'(0));
        chk("tie_count",    128'(count_t),   128'(1));

        // Asynchronous reset in the middle of a drain.
        do_reset();
        apply(1, 32'h00, 0);
        apply(1, 32'h04, 0);
        apply(1, 32'h08, 0);
        apply(1, 32'h0C, 0);
        apply(1, 32'h10, 0);
        apply(0, 32'h00, 1);
        chk("mid_count",    128'(count), 128'(3));
        chk("mid_ovf",      128'(ovf),   128'(1));
        tr_ready = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_count",   128'(count),    128'(0));
        chk("arst_valid",   128'(tr_valid), 128'(0));
        chk("arst_ovf",     128'(ovf),      128'(0));
        chk("arst_data",    128'(tr_data),  128'(0));
        chk("arst_halted",  128'(halted),   128'(0));
        chk("arst_timeout", 128'(timeout),  128'(0));
        chk("arst_done",    128'(done),     128'(0));
        @(negedge clk);
        rstn = 1'b1;
        tr_ready = 1'b0;
        apply(1, 32'h50, 0);
        chk("post_rst_count", 128'(count),   128'(1));
        chk("post_rst_data",  128'(tr_data), 128'(exp_entry(32'h50)));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/commit_tracer.md
COMMIT_TRACER -- requirements
Module: commit_tracer

Interface
REQ-001 Parameter DEPTH, 16, trace FIFO entries; power of two, at least 2.
REQ-002 Parameter HALT_PC, 32'h00000048, PC whose commit ends the capture.
REQ-003 Parameter MAX_CYCLES, 1000, RUN-state cycle budget before timeout.
REQ-004 Port clk  input  1  single clock; all state on rising edge.
REQ-005 Port rstn  input  1  reset, asynchronous, active-low.
REQ-006 Port commit  input  1  CPU retires one instruction this cycle.
REQ-007 Port pc, instr  input  32 each  retiring instruction's PC and word.
REQ-008 Port rf_we  input  1; rf_waddr  input  5; rf_wdata  input  32: retiring register write.
REQ-009 Port cpu_hold  output  1  stall request to CPU, high while FIFO full in RUN.
REQ-010 Port tr_valid  output  1; tr_ready  input  1; tr_data  output  ENTRY_W: trace drain stream.
REQ-011 Port halted, timeout, ovf, done  output  1 each  status flags.
REQ-012 Port count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 States: RUN, HALTED, TIMEOUT; reset enters RUN.
REQ-014 In RUN, commit=1 with count<DEPTH, or count==DEPTH with a pop in the same cycle, pushes entry {pc, instr, rf_we, rf_waddr, rf_wdata} on that edge.
REQ-015 Latency: a pushed entry is visible on tr_data with tr_valid=1 no earlier than the cycle after the commit.
REQ-016 tr_valid = (count!=0); pop occurs when tr_valid && tr_ready; tr_data holds the oldest entry and is stable while tr_valid && !tr_ready.
REQ-017 Commit in RUN with FIFO full and no pop: entry dropped, ovf set sticky until reset.
REQ-018 cpu_hold = (state==RUN) && (count==DEPTH), combinational.
REQ-019 Read/write pointers wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-020 Commit with pc==HALT_PC in RUN is captured per REQ-014/017, then state moves to HALTED on the same edge; halted=1 from the next cycle.
REQ-021 cyc_cnt increments every RUN cycle; when it reaches MAX_CYCLES-1 and no halt commit occurs, state moves to TIMEOUT; timeout=1 from the next cycle.
REQ-022 Halt commit and timeout on the same cycle: HALTED wins, timeout stays 0.
REQ-023 In HALTED/TIMEOUT commits are ignored, cyc_cnt frozen, draining continues.
REQ-024 done = (state!=RUN) && (count==0).

Reset
REQ-025 rstn low immediately clears FIFO contents, pointers, count, cyc_cnt, and state to RUN; outputs go to cpu_hold=0, tr_valid=0, tr_data=0, halted=0, timeout=0, ovf=0, done=0, count=0.
REQ-026 Reset asserted mid-capture or mid-drain discards all entries; no partial pop is reported.

Configuration
REQ-027 With TRACE_RF_EN defined, entries carry the register-write fields, ENTRY_W=102: pc[101:70], instr[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0].
REQ-028 Without TRACE_RF_EN, entries carry {pc, instr} only with ENTRY_W=64; rf_* inputs stay on the port list and are ignored.

Structure
REQ-029 Package commit_tracer_pkg holds the state enum, field widths, and ENTRY_W, computed under TRACE_RF_EN.
REQ-030 Storage is one sub-module, trace_fifo: parameterised synchronous FIFO with push/pop/full/empty/count; FSM, timeout counter, and halt detection stay in commit_tracer.

Verification
REQ-031 Three commits (pc 0,4,8; rf_we=1, waddr 7, wdata 5) with tr_ready=1 produce three tr_data beats in order with matching fields, each one cycle after its commit.
REQ-032 With DEPTH=4 and tr_ready=0, five commits give cpu_hold=1 after the fourth, ovf=1, and count=4; draining then yields pc 0,4,8,C only.
REQ-033 Commit with pc=32'h48 gives halted=1 next cycle; a later commit at pc=4C is not captured; done=1 after the drain empties.
REQ-034 With MAX_CYCLES=10 and no halt commit, timeout=1 after the tenth RUN cycle and cyc_cnt is frozen.
REQ-035 With count=4 and DEPTH=4, a commit plus a simultaneous pop leaves count=4 with ovf=0.
REQ-036 rstn pulsed low mid-drain with count=3 gives count=0, tr_valid=0, ovf=0, state RUN asynchronously; without TRACE_RF_EN, tr_data is 64 bits {pc, instr}.
